// File: rtl/plate_result_pkg.sv
// Shared types and constants for the plate result packer.
package plate_result_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned WORD_W    = 128;
  localparam int unsigned MAX_CHARS = 15;
  localparam int unsigned HDR_BYTE  = 15;

  typedef logic [WORD_W-1:0] pio_word_t;

  typedef enum logic [1:0] {
    EMPTY_WAIT    = 2'd0,
    SETTLE        = 2'd1,
    READY         = 2'd2,
    EMPTY_RELEASE = 2'd3
  } rd_state_e;

  // Header byte: sequence nibble above the character count.
  function automatic logic [BYTE_W-1:0] make_header(input logic [3:0] seq,
                                                    input logic [3:0] count);
    return {seq, count};
  endfunction

endpackage

// File: rtl/plate_word_fifo.sv
// DEPTH x 128-bit synchronous FIFO with combinational head read.
module plate_word_fifo
  import plate_result_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       i_clr,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  pio_word_t                  i_data,
  output pio_word_t                  o_head,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  pio_word_t       r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            w_push;
  logic            w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full && !i_clr;
  assign w_pop   = i_pop && !o_empty && !i_clr;
  assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];
  assign o_count = r_count;

  // Storage; contents are only observed through a valid occupancy.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers and occupancy; clear wins over push and pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CW'(1);
    end
  end

endmodule

// File: rtl/plate_result_packer.sv
// Packs OCR plate characters into 128-bit words, queues them and paces the
// PIO read port via block_read. Optional macro PLATE_SEQ_EN adds a 4-bit
// push sequence number in the upper nibble of the header byte.
module plate_result_packer
  import plate_result_pkg::*;
#(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned STALL_LIMIT = 64
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       char_valid,
  input  logic [7:0]                 char_data,
  input  logic                       plate_end,
  output logic                       char_ready,
  output pio_word_t                  pio_out,
  output logic                       block_read,
  input  logic                       read_request,
  output logic [$clog2(DEPTH+1)-1:0] word_count
);

  localparam int unsigned CW         = $clog2(DEPTH + 1);
  localparam int unsigned IW         = 4;
  localparam int unsigned SW         = (STALL_LIMIT > 1) ? $clog2(STALL_LIMIT) : 1;
  localparam int unsigned STALL_LAST = (STALL_LIMIT > 0) ? STALL_LIMIT - 1 : 0;

  logic [MAX_CHARS*BYTE_W-1:0] r_asm;
  logic [MAX_CHARS*BYTE_W-1:0] w_merged;
  logic [IW-1:0]               r_idx;
  logic                        w_accept;
  logic                        w_last;
  logic                        w_push;
  logic                        w_pop;
  logic                        w_full;
  logic                        w_empty;
  logic [CW-1:0]               w_count;
  logic [3:0]                  w_seq;
  pio_word_t                   w_word;

  rd_state_e                   r_state;
  rd_state_e                   w_state_nxt;
  logic [SW-1:0]               r_stall_cnt;
  logic [SW-1:0]               w_stall_nxt;
  logic                        r_block_read;

  assign char_ready = !w_full;
  assign word_count = w_count;
  assign block_read = r_block_read;
  assign w_accept   = char_valid && char_ready && !flush;
  assign w_last     = plate_end || (r_idx == IW'(MAX_CHARS - 1));
  assign w_push     = w_accept && w_last;
  assign w_pop      = (r_state == READY) && read_request && !flush;

  // Assembly bytes with the incoming character dropped into slot idx.
  always_comb begin
    w_merged = r_asm;
    for (int i = 0; i < MAX_CHARS; i++) begin
      if (r_idx == IW'(i)) w_merged[i*BYTE_W +: BYTE_W] = char_data;
    end
  end

  // Finished word: characters in bytes 0..14, header in byte 15.
  always_comb begin
    w_word = '0;
    w_word[MAX_CHARS*BYTE_W-1:0]        = w_merged;
    w_word[HDR_BYTE*BYTE_W +: BYTE_W]   = make_header(w_seq, r_idx + IW'(1));
  end

`ifdef PLATE_SEQ_EN
  logic [3:0] r_seq;

  // Push sequence number, wraps naturally at 16.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    r_seq <= '0;
    else if (flush)  r_seq <= '0;
    else if (w_push) r_seq <= r_seq + 4'd1;
  end

  assign w_seq = r_seq;
`else
  assign w_seq = 4'h0;
`endif

  // Packer: collect characters, restart after each pushed word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_asm <= '0;
      r_idx <= '0;
    end else if (flush) begin
      r_asm <= '0;
      r_idx <= '0;
    end else if (w_accept) begin
      if (w_last) begin
        r_asm <= '0;
        r_idx <= '0;
      end else begin
        r_asm <= w_merged;
        r_idx <= r_idx + IW'(1);
      end
    end
  end

  plate_word_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clr   (flush),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_word),
    .o_head  (pio_out),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Read FSM next state; SETTLE gives the read port a cycle to capture the head.
  always_comb begin
    w_state_nxt = r_state;
    w_stall_nxt = r_stall_cnt;
    if (flush) begin
      w_state_nxt = EMPTY_WAIT;
      w_stall_nxt = '0;
    end else begin
      case (r_state)
        EMPTY_WAIT: begin
          if (!w_empty) begin
            w_state_nxt = SETTLE;
            w_stall_nxt = '0;
          end else if (read_request) begin
            if ((STALL_LIMIT != 0) && (r_stall_cnt == SW'(STALL_LAST))) begin
              w_state_nxt = EMPTY_RELEASE;
              w_stall_nxt = '0;
            end else begin
              w_stall_nxt = r_stall_cnt + SW'(1);
            end
          end
        end
        SETTLE: w_state_nxt = READY;
        READY: begin
          if (read_request) begin
            w_state_nxt = ((w_count > CW'(1)) || w_push) ? SETTLE : EMPTY_WAIT;
          end
        end
        EMPTY_RELEASE: begin
          if (!w_empty) begin
            w_state_nxt = SETTLE;
          end else if (read_request) begin
            w_state_nxt = EMPTY_WAIT;
            w_stall_nxt = '0;
          end
        end
        default: w_state_nxt = EMPTY_WAIT;
      endcase
    end
  end

  // Read FSM state, stall counter and registered block_read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= EMPTY_WAIT;
      r_stall_cnt  <= '0;
      r_block_read <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_stall_cnt  <= w_stall_nxt;
      r_block_read <= !((w_state_nxt == READY) || (w_state_nxt == EMPTY_RELEASE));
    end
  end

endmodule
